// File: rtl/data_mem_mmio.sv
// Data-side memory for the single-cycle MIPS core: word RAM plus an MMIO window
// holding a compare timer and an optional GPIO register (enabled by DATA_MEM_MMIO_GPIO_EN).
module data_mem_mmio #(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        mem_write,
  output logic [31:0] read_data,
  output logic        timer_irq,
  output logic [7:0]  gpio_out
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [5:0] REG_COUNT  = 6'd0;
  localparam logic [5:0] REG_CMP    = 6'd1;
  localparam logic [5:0] REG_STATUS = 6'd2;
  localparam logic [5:0] REG_CTRL   = 6'd3;
  localparam logic [5:0] REG_GPIO   = 6'd4;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] word_idx;
  logic [5:0]    reg_sel;
  logic          is_mmio;

  logic [31:0] count;
  logic [31:0] cmp;
  logic        match;
  logic [2:0]  ctrl;
  logic [7:0]  gpio_val;

  logic wr_count, wr_cmp, wr_status, wr_ctrl;
  logic hit;

  // Byte offset bits are dropped: every access is a whole word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[1:0];

  assign is_mmio  = (addr[31:8] == MMIO_BASE[31:8]);
  assign reg_sel  = addr[7:2];
  assign word_idx = addr[AW+1:2];

  assign wr_count  = mem_write && is_mmio && (reg_sel == REG_COUNT);
  assign wr_cmp    = mem_write && is_mmio && (reg_sel == REG_CMP);
  assign wr_status = mem_write && is_mmio && (reg_sel == REG_STATUS);
  assign wr_ctrl   = mem_write && is_mmio && (reg_sel == REG_CTRL);

  // Compare uses the registered COUNT, so a same-cycle COUNT write cannot mask a match.
  assign hit = ctrl[0] && (count == cmp);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      cmp   <= 32'hFFFF_FFFF;
      match <= 1'b0;
      ctrl  <= '0;
    end else begin
      if (wr_count)
        count <= write_data;
      else if (ctrl[0])
        count <= (hit && ctrl[1]) ? 32'd0 : count + 32'd1;

      if (wr_cmp)
        cmp <= write_data;

      if (hit)
        match <= 1'b1;
      else if (wr_status && write_data[0])
        match <= 1'b0;

      if (wr_ctrl)
        ctrl <= write_data[2:0];
    end
  end

`ifdef DATA_MEM_MMIO_GPIO_EN
  logic wr_gpio;
  assign wr_gpio = mem_write && is_mmio && (reg_sel == REG_GPIO);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      gpio_val <= '0;
    else if (wr_gpio)
      gpio_val <= write_data[7:0];
  end
`else
  assign gpio_val = '0;
`endif

  assign gpio_out  = gpio_val;
  assign timer_irq = match & ctrl[2];

  // NOTE: the RAM array has no reset branch; clearing it would turn it into a flop bank.
  always_ff @(posedge clk) begin
    if (mem_write && !is_mmio)
      mem[word_idx] <= write_data;
  end

  // NOTE: read_data gets a default first so no path through the mux infers a latch.
  always_comb begin
    read_data = '0;
    if (is_mmio) begin
      case (reg_sel)
        REG_COUNT:  read_data = count;
        REG_CMP:    read_data = cmp;
        REG_STATUS: read_data = {31'd0, match};
        REG_CTRL:   read_data = {29'd0, ctrl};
        REG_GPIO:   read_data = {24'd0, gpio_val};
        default:    read_data = '0;
      endcase
    end else begin
      read_data = mem[word_idx];
    end
  end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Self-checking bench for data_mem_mmio: directed test-plan steps followed by
// randomized traffic, all compared against a behavioural model of the memory map.
module tb_data_mem_mmio;

  localparam logic [31:0] BASE   = 32'hFFFF_FF00;
  localparam logic [31:0] A_COUNT  = BASE + 32'h00;
  localparam logic [31:0] A_CMP    = BASE + 32'h04;
  localparam logic [31:0] A_STATUS = BASE + 32'h08;
  localparam logic [31:0] A_CTRL   = BASE + 32'h0C;
  localparam logic [31:0] A_GPIO   = BASE + 32'h10;
`ifdef DATA_MEM_MMIO_GPIO_EN
  localparam bit GPIO_EN = 1'b1;
`else
  localparam bit GPIO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        mem_write;
  logic [31:0] read_data;
  logic        timer_irq;
  logic [7:0]  gpio_out;

  int checks = 0;
  int errors = 0;

  data_mem_mmio #(.DEPTH(64), .MMIO_BASE(BASE)) dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .write_data (write_data),
    .mem_write  (mem_write),
    .read_data  (read_data),
    .timer_irq  (timer_irq),
    .gpio_out   (gpio_out)
  );

  always #5 clk = ~clk;

  // Reference model state: plain variables and an array for the 64-word RAM.
  logic [31:0] m_count, m_cmp;
  logic        m_match;
  logic [2:0]  m_ctrl;
  logic [7:0]  m_gpio;
  logic [31:0] m_mem [64];
  bit          m_valid [64];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_mmio_addr(input logic [31:0] a);
    return (a >> 8) == (BASE >> 8);
  endfunction

  function automatic int ram_index(input logic [31:0] a);
    return int'((a / 4) % 64);
  endfunction

  function automatic int mmio_offset(input logic [31:0] a);
    return int'(a % 256) / 4 * 4;
  endfunction

  task automatic model_reset();
    m_count = 0;
    m_cmp   = 32'hFFFF_FFFF;
    m_match = 0;
    m_ctrl  = 0;
    m_gpio  = 0;
  endtask

  // Applies one rising edge to the model using the inputs present during the cycle.
  task automatic model_edge(input logic [31:0] a, input logic [31:0] wd, input logic we);
    logic [31:0] next_count;
    bit          matched;
    int          off;
    matched    = (m_ctrl[0] == 1'b1) && (m_count == m_cmp);
    next_count = m_count;
    if (m_ctrl[0]) next_count = (matched && m_ctrl[1]) ? 32'd0 : m_count + 1;
    off = mmio_offset(a);
    if (we && !is_mmio_addr(a)) begin
      m_mem[ram_index(a)]   = wd;
      m_valid[ram_index(a)] = 1'b1;
    end
    if (we && is_mmio_addr(a)) begin
      if (off == 'h00) next_count = wd;
      if (off == 'h04) m_cmp = wd;
      if (off == 'h08 && wd[0]) m_match = 0;
      if (off == 'h0C) m_ctrl = wd[2:0];
      if (off == 'h10 && GPIO_EN) m_gpio = wd[7:0];
    end
    if (matched) m_match = 1;
    m_count = next_count;
  endtask

  // Returns 1 when the model knows the value at this address (unwritten RAM is unknown).
  function automatic bit model_read(input logic [31:0] a, output logic [31:0] v);
    v = 0;
    if (!is_mmio_addr(a)) begin
      v = m_mem[ram_index(a)];
      return m_valid[ram_index(a)];
    end
    case (mmio_offset(a))
      'h00: v = m_count;
      'h04: v = m_cmp;
      'h08: v = {31'd0, m_match};
      'h0C: v = {29'd0, m_ctrl};
      'h10: v = GPIO_EN ? {24'd0, m_gpio} : 32'd0;
      default: v = 0;
    endcase
    return 1'b1;
  endfunction

  task automatic check_outputs(input string tag);
    logic [31:0] v;
    if (model_read(addr, v)) check({tag, "_rd"}, read_data, v);
    check({tag, "_irq"}, {31'd0, timer_irq}, {31'd0, m_match & m_ctrl[2]});
    check({tag, "_gpio"}, {24'd0, gpio_out}, GPIO_EN ? {24'd0, m_gpio} : 32'd0);
  endtask

  // Drive one cycle's inputs just after the falling edge and compare against the model.
  task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic we, input string tag);
    addr = a; write_data = wd; mem_write = we;
    #1;
    check_outputs(tag);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(addr, write_data, mem_write);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] a, wd;
    logic        we;
    int          sel;
    logic [31:0] exp_gpio;

    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    reset = 1'b1; addr = A_CMP; write_data = 0; mem_write = 1'b0;
    model_reset();
    #1;
    check("reset_cmp", read_data, 32'hFFFF_FFFF);
    check_outputs("reset");
    addr = A_COUNT; #1;
    check("reset_count", read_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // RAM store, aliasing and ignored byte offset.
    drive(32'h0000_0008, 32'hDEAD_BEEF, 1'b1, "ram_st"); tick();
    drive(32'h0000_0008, 0, 1'b0, "ram_ld");   check("ram_ld", read_data, 32'hDEAD_BEEF); tick();
    drive(32'h0000_0108, 0, 1'b0, "ram_alias"); check("ram_alias", read_data, 32'hDEAD_BEEF); tick();
    drive(32'h0000_000B, 0, 1'b0, "ram_lowb");  check("ram_lowb", read_data, 32'hDEAD_BEEF); tick();

    // Timer match with auto-clear and interrupt.
    drive(A_CMP, 5, 1'b1, "t_cmp"); tick();
    drive(A_CTRL, 7, 1'b1, "t_ctrl"); tick();
    for (int i = 0; i <= 5; i++) begin
      drive(A_COUNT, 0, 1'b0, "t_run");
      check("t_count_seq", read_data, 32'(i));
      check("t_irq_low", {31'd0, timer_irq}, 32'd0);
      tick();
    end
    drive(A_COUNT, 0, 1'b0, "t_wrap0");
    check("t_autoclr", read_data, 32'd0);
    check("t_irq_high", {31'd0, timer_irq}, 32'd1);
    tick();
    drive(A_STATUS, 1, 1'b1, "t_w1c"); tick();
    drive(A_STATUS, 0, 1'b0, "t_cleared");
    check("t_irq_cleared", {31'd0, timer_irq}, 32'd0);
    check("t_status_cleared", read_data, 32'd0);
    tick();

    // Collision: COUNT write in the match cycle wins over auto-clear, MATCH still sets.
    drive(A_CMP, 10, 1'b1, "c_cmp"); tick();
    for (int k = 0; k < 20 && m_count != 10; k++) begin
      drive(A_COUNT, 0, 1'b0, "c_wait"); tick();
    end
    drive(A_COUNT, 100, 1'b1, "c_wr");
    check("c_at_cmp", read_data, 32'd10);
    tick();
    drive(A_COUNT, 0, 1'b0, "c_count"); check("c_count_100", read_data, 32'd100); tick();
    drive(A_STATUS, 0, 1'b0, "c_status"); check("c_match_set", read_data, 32'd1); tick();

    // Collision: MATCH set beats a same-cycle W1C.
    drive(A_COUNT, 9, 1'b1, "w_ld9"); tick();
    drive(A_STATUS, 1, 1'b1, "w_clr"); tick();
    drive(A_STATUS, 1, 1'b1, "w_coll"); check("w_pre", read_data, 32'd0); tick();
    drive(A_STATUS, 0, 1'b0, "w_post"); check("w_set_wins", read_data, 32'd1); tick();

    // Wrap through 32'hFFFF_FFFF without auto-clear.
    drive(A_CTRL, 1, 1'b1, "r_ctrl"); tick();
    drive(A_CMP, 3, 1'b1, "r_cmp"); tick();
    drive(A_COUNT, 32'hFFFF_FFFE, 1'b1, "r_ld"); tick();
    drive(A_STATUS, 1, 1'b1, "r_clr"); tick();
    for (int i = 0; i <= 4; i++) begin
      drive(A_COUNT, 0, 1'b0, "r_run");
      check("r_count_seq", read_data, 32'hFFFF_FFFF + 32'(i));
      tick();
    end
    drive(A_STATUS, 0, 1'b0, "r_status");
    check("r_match", read_data, 32'd1);
    check("r_irq_masked", {31'd0, timer_irq}, 32'd0);
    tick();

    // GPIO register (reads back 0 when the feature is not built).
    exp_gpio = GPIO_EN ? 32'h0000_00A5 : 32'd0;
    drive(A_GPIO, 32'h0000_00A5, 1'b1, "g_wr"); tick();
    drive(A_GPIO, 0, 1'b0, "g_rd");
    check("g_readback", read_data, exp_gpio);
    check("g_out", {24'd0, gpio_out}, exp_gpio);
    tick();

    // Async reset between edges while COUNT=7 and MATCH=1.
    drive(A_CTRL, 5, 1'b1, "a_ctrl"); tick();
    drive(A_CMP, 6, 1'b1, "a_cmp"); tick();
    drive(A_COUNT, 5, 1'b1, "a_ld"); tick();
    drive(A_COUNT, 0, 1'b0, "a_5"); tick();
    drive(A_COUNT, 0, 1'b0, "a_6"); tick();
    drive(A_COUNT, 0, 1'b0, "a_7");
    check("a_count7", read_data, 32'd7);
    check("a_irq_before", {31'd0, timer_irq}, 32'd1);
    #1 reset = 1'b1;
    #1;
    model_reset();
    check("a_count_async", read_data, 32'd0);
    check("a_irq_async", {31'd0, timer_irq}, 32'd0);
    check("a_gpio_async", {24'd0, gpio_out}, 32'd0);
    addr = A_CMP; #1;
    check("a_cmp_async", read_data, 32'hFFFF_FFFF);
    @(negedge clk);
    reset = 1'b0;

    // Store 8'h3C to GPIO: visible only when the feature is built.
    exp_gpio = GPIO_EN ? 32'h0000_003C : 32'd0;
    drive(A_GPIO, 32'h0000_003C, 1'b1, "m_wr"); tick();
    drive(A_GPIO, 0, 1'b0, "m_rd");
    check("m_readback", read_data, exp_gpio);
    check("m_out", {24'd0, gpio_out}, exp_gpio);
    tick();

    // Randomized traffic over RAM (with aliasing) and all MMIO offsets.
    for (int n = 0; n < 400; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 4) begin
        a = ($urandom() & 32'h0000_0F00) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
        wd = $urandom();
      end else begin
        case ($urandom_range(0, 6))
          0: a = A_COUNT;
          1: a = A_CMP;
          2: a = A_STATUS;
          3: a = A_CTRL;
          4: a = A_GPIO;
          5: a = BASE + 32'h14;
          default: a = BASE + $urandom_range(0, 255);
        endcase
        a = a | $urandom_range(0, 3);
        wd = (mmio_offset(a) <= 'h04) ? $urandom_range(0, 24) : $urandom();
      end
      we = ($urandom_range(0, 2) == 0);
      drive(a, wd, we, "rnd");
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
